// File: rtl/stim_ctrl_pkg.sv
// Shared types and constants for the stimulus-window controller.
package stim_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 15;

    // Command word layout: start flag in bit 0, window length above it.
    localparam int CMD_START_BIT = 0;
    localparam int CMD_LEN_LSB   = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSED = 2'd2
    } stim_state_e;

endpackage

// File: rtl/stim_tick_detect.sv
// Turns the sampled user-clock level into the one-cycle "counted tick".
module stim_tick_detect #(
    parameter bit EDGE_DETECT = 1'b1
) (
    input  logic clk_ref,
    input  logic rst,
    input  logic user_tick_i,
    output logic tick_o
);

    logic tick_q;

    // Previous user-clock level, used for rising-edge detection.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= user_tick_i;
        end
    end

    assign tick_o = EDGE_DETECT ? (user_tick_i & ~tick_q) : user_tick_i;

endmodule

// File: rtl/stim_window_ctrl.sv
// Stimulus-enable window controller: runs a window of L counted ticks,
// with a one-deep pending command slot, pause/abort on run_verif_i drop,
// explicit abort, and done/aborted/drop status pulses.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no window; r_en low; commands load directly
// ST_ACTIVE | window running (remaining_o==0 means a zero-length window
//           | loaded from the pending slot, finishing next cycle)
// ST_PAUSED | window frozen while run_verif_i is low (PAUSE_MODE=1 only)
module stim_window_ctrl
    import stim_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter bit EDGE_DETECT = 1'b1,
    parameter bit PAUSE_MODE  = 1'b1
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             cmd_valid_i,
    input  logic [CNT_W:0]   cmd_i,
    input  logic             user_tick_i,
    input  logic             run_verif_i,
    input  logic             abort_i,
    output logic             cmd_ready_o,
    output logic             r_en_stimuli_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic             cmd_drop_o,
    output logic [CNT_W-1:0] remaining_o
);

    stim_state_e      state_q;
    logic [CNT_W-1:0] rem_q;
    logic             pend_vld_q;
    logic [CNT_W-1:0] pend_len_q;
    logic             ren_q;
    logic             done_q;
    logic             aborted_q;
    logic             drop_q;

    logic             tick;
    logic             start_req;
    logic             accept;
    logic [CNT_W-1:0] cmd_len;
    logic             next_has;
    logic [CNT_W-1:0] next_len;
    logic             finish;

    stim_tick_detect #(
        .EDGE_DETECT (EDGE_DETECT)
    ) u_tick (
        .clk_ref     (clk_ref),
        .rst         (rst),
        .user_tick_i (user_tick_i),
        .tick_o      (tick)
    );

    assign cmd_len     = cmd_i[CMD_LEN_LSB +: CNT_W];
    assign start_req   = cmd_valid_i & cmd_i[CMD_START_BIT];
    assign cmd_ready_o = ~rst & ((state_q == ST_IDLE) | ~pend_vld_q);
    assign accept      = start_req & cmd_ready_o;

    // Window that follows a completion: pending slot first, otherwise a
    // command accepted in the completion cycle itself.
    assign next_has = pend_vld_q | accept;
    assign next_len = pend_vld_q ? pend_len_q : cmd_len;

    // A zero-length window from the slot completes unconditionally; a normal
    // window completes on a counted tick at remaining==1 while running.
    assign finish = (state_q == ST_ACTIVE) &&
                    ((rem_q == '0) || (run_verif_i && tick && (rem_q == CNT_W'(1))));

    // Window FSM with registered outputs.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            pend_vld_q <= 1'b0;
            pend_len_q <= '0;
            ren_q      <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            drop_q    <= start_req & ~cmd_ready_o & ~abort_i;

            if (abort_i) begin
                aborted_q  <= (state_q != ST_IDLE) | pend_vld_q;
                state_q    <= ST_IDLE;
                rem_q      <= '0;
                ren_q      <= 1'b0;
                pend_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (accept) begin
                            if (cmd_len == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_ACTIVE;
                                rem_q   <= cmd_len;
                                ren_q   <= 1'b1;
                            end
                        end
                    end

                    ST_ACTIVE: begin
                        if (finish) begin
                            done_q     <= 1'b1;
                            pend_vld_q <= 1'b0;
                            if (next_has) begin
                                rem_q <= next_len;
                                ren_q <= (next_len != '0);
                            end else begin
                                state_q <= ST_IDLE;
                                rem_q   <= '0;
                                ren_q   <= 1'b0;
                            end
                        end else if (!run_verif_i) begin
                            ren_q <= 1'b0;
                            if (PAUSE_MODE) begin
                                state_q <= ST_PAUSED;
                                if (accept) begin
                                    pend_vld_q <= 1'b1;
                                    pend_len_q <= cmd_len;
                                end
                            end else begin
                                state_q    <= ST_IDLE;
                                rem_q      <= '0;
                                pend_vld_q <= 1'b0;
                                aborted_q  <= 1'b1;
                            end
                        end else begin
                            if (tick) begin
                                rem_q <= rem_q - CNT_W'(1);
                            end
                            if (accept) begin
                                pend_vld_q <= 1'b1;
                                pend_len_q <= cmd_len;
                            end
                        end
                    end

                    ST_PAUSED: begin
                        if (run_verif_i) begin
                            state_q <= ST_ACTIVE;
                            ren_q   <= 1'b1;
                        end
                        if (accept) begin
                            pend_vld_q <= 1'b1;
                            pend_len_q <= cmd_len;
                        end
                    end

                    default: begin
                        state_q <= ST_IDLE;
                        rem_q   <= '0;
                        ren_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign r_en_stimuli_o = ren_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = done_q;
    assign aborted_o      = aborted_q;
    assign cmd_drop_o     = drop_q;
    assign remaining_o    = rem_q;

endmodule

// File: tb/tb_stim_window_ctrl.sv
// Bench for stim_window_ctrl: two instances (edge/pause and level/abort)
// driven by shared stimulus, checked every cycle against a window model.
module tb_stim_window_ctrl;

    localparam int W = 15;

    logic         clk_ref = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [W:0]   cmd = '0;
    logic         user_tick = 1'b0;
    logic         run_verif = 1'b1;
    logic         abort_r = 1'b0;

    logic         rdy_p, ren_p, busy_p, done_p, ab_p, drop_p;
    logic [W-1:0] rem_p;
    logic         rdy_a, ren_a, busy_a, done_a, ab_a, drop_a;
    logic [W-1:0] rem_a;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_on = 1'b0;

    always #5 clk_ref = ~clk_ref;

    stim_window_ctrl #(.CNT_W(W), .EDGE_DETECT(1'b1), .PAUSE_MODE(1'b1)) u_p (
        .clk_ref(clk_ref), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
        .user_tick_i(user_tick), .run_verif_i(run_verif), .abort_i(abort_r),
        .cmd_ready_o(rdy_p), .r_en_stimuli_o(ren_p), .busy_o(busy_p), .done_o(done_p),
        .aborted_o(ab_p), .cmd_drop_o(drop_p), .remaining_o(rem_p));

    stim_window_ctrl #(.CNT_W(W), .EDGE_DETECT(1'b0), .PAUSE_MODE(1'b0)) u_a (
        .clk_ref(clk_ref), .rst(rst), .cmd_valid_i(cmd_valid), .cmd_i(cmd),
        .user_tick_i(user_tick), .run_verif_i(run_verif), .abort_i(abort_r),
        .cmd_ready_o(rdy_a), .r_en_stimuli_o(ren_a), .busy_o(busy_a), .done_o(done_a),
        .aborted_o(ab_a), .cmd_drop_o(drop_a), .remaining_o(rem_a));

    // Abstract view: is a window open, is it frozen, ticks left, queued length.
    typedef struct {
        bit win;
        bit paused;
        int rem;
        bit pv;
        int pl;
        bit prev;
        bit done;
        bit aborted;
        bit drop;
    } mdl_t;

    mdl_t m_p, m_a;

    function automatic mdl_t step(input mdl_t m, input bit pm, input bit ed, input bit r,
                                  input bit cv, input logic [W:0] c, input bit ut,
                                  input bit run, input bit ab);
        mdl_t n;
        bit tick, start, ready, acc;
        int len;
        n = m;
        n.done = 0; n.aborted = 0; n.drop = 0;
        tick = ed ? (ut && !m.prev) : ut;
        n.prev = ut;
        if (r) begin
            n = '{default:0};
            return n;
        end
        start = cv && c[0];
        len   = int'(c[W:1]);
        ready = !m.win || !m.pv;
        acc   = start && ready;
        if (ab) begin
            n = '{default:0};
            n.prev = ut;
            n.aborted = m.win || m.pv;
            return n;
        end
        n.drop = start && !ready;
        if (!m.win) begin
            if (acc) begin
                if (len == 0) n.done = 1;
                else begin n.win = 1; n.rem = len; end
            end
            return n;
        end
        if (m.rem == 0 || (run && !m.paused && tick && m.rem == 1)) begin
            n.done = 1;
            if (m.pv) begin n.rem = m.pl; n.pv = 0; end
            else if (acc) n.rem = len;
            else begin n.win = 0; n.rem = 0; end
            return n;
        end
        if (acc) begin n.pv = 1; n.pl = len; end
        if (m.paused) begin
            if (run) n.paused = 0;
            return n;
        end
        if (!run) begin
            if (pm) n.paused = 1;
            else begin n.win = 0; n.rem = 0; n.pv = 0; n.aborted = 1; end
            return n;
        end
        if (tick) n.rem = m.rem - 1;
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic cmp_inst(input string nm, input mdl_t m, input logic rdy, input logic ren,
                            input logic busy, input logic done, input logic ab,
                            input logic drop, input logic [W-1:0] rem);
        chk({nm, "_ready"},   32'(rdy),  32'(!rst && (!m.win || !m.pv)));
        chk({nm, "_r_en"},    32'(ren),  32'(m.win && !m.paused && m.rem != 0));
        chk({nm, "_busy"},    32'(busy), 32'(m.win));
        chk({nm, "_done"},    32'(done), 32'(m.done));
        chk({nm, "_aborted"}, 32'(ab),   32'(m.aborted));
        chk({nm, "_drop"},    32'(drop), 32'(m.drop));
        chk({nm, "_remain"},  32'(rem),  32'(m.rem));
    endtask

    // Advance both models on the same edge the DUTs see.
    always @(posedge clk_ref) begin
        m_p <= step(m_p, 1'b1, 1'b1, rst, cmd_valid, cmd, user_tick, run_verif, abort_r);
        m_a <= step(m_a, 1'b0, 1'b0, rst, cmd_valid, cmd, user_tick, run_verif, abort_r);
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk_ref) begin
        if (chk_on) begin
            cmp_inst("p", m_p, rdy_p, ren_p, busy_p, done_p, ab_p, drop_p, rem_p);
            cmp_inst("a", m_a, rdy_a, ren_a, busy_a, done_a, ab_a, drop_a, rem_a);
        end
    end

    // Running event counters for the directed scenarios.
    int c_done_p = 0, c_done_a = 0, c_ren_p = 0, c_ren_a = 0;
    int c_fall_p = 0, c_fall_a = 0, c_ab_a = 0, c_drop_p = 0;
    logic pren_p = 1'b0, pren_a = 1'b0;
    always @(negedge clk_ref) begin
        c_done_p += int'(done_p === 1'b1);
        c_done_a += int'(done_a === 1'b1);
        c_ren_p  += int'(ren_p === 1'b1);
        c_ren_a  += int'(ren_a === 1'b1);
        c_ab_a   += int'(ab_a === 1'b1);
        c_drop_p += int'(drop_p === 1'b1);
        c_fall_p += int'(pren_p === 1'b1 && ren_p === 1'b0);
        c_fall_a += int'(pren_a === 1'b1 && ren_a === 1'b0);
        pren_p = ren_p;
        pren_a = ren_a;
    end

    // Apply one cycle of inputs; return just after the following negedge.
    task automatic drive(input bit r, input bit cv, input int len, input bit st,
                         input bit ut, input bit run, input bit ab);
        rst       = r;
        cmd_valid = cv;
        cmd       = {len[W-1:0], st};
        user_tick = ut;
        run_verif = run;
        abort_r   = ab;
        @(negedge clk_ref);
        #1;
    endtask

    initial begin
        int dp, da, rp, ra, fp, fa, aa, dr;

        // Reset
        drive(1, 0, 0, 0, 0, 1, 0);
        chk_on = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 0);
        chk("ready_in_reset", 32'(rdy_p), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("ready_after_reset", 32'(rdy_p), 1);
        chk("ren_after_reset", 32'(ren_p), 0);

        // Single L=3 window, user clock toggling every two cycles
        dp = c_done_p; da = c_done_a; rp = c_ren_p; ra = c_ren_a;
        drive(0, 1, 3, 1, 0, 1, 0);
        chk("A_rem_load", 32'(rem_p), 3);
        chk("A_ren_load", 32'(ren_p), 1);
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 0, (i % 4) < 2, 1, 0);
            if (i == 0) chk("A_rem_2", 32'(rem_p), 2);
            if (i == 4) chk("A_rem_1", 32'(rem_p), 1);
            if (i == 8) chk("A_rem_0", 32'(rem_p), 0);
        end
        chk("A_ren_cycles_p", 32'(c_ren_p - rp), 9);
        chk("A_ren_cycles_a", 32'(c_ren_a - ra), 5);
        chk("A_done_p", 32'(c_done_p - dp), 1);
        chk("A_done_a", 32'(c_done_a - da), 1);

        // Back-to-back L=4 then L=2, third command dropped
        dp = c_done_p; da = c_done_a; rp = c_ren_p; ra = c_ren_a;
        fp = c_fall_p; fa = c_fall_a; dr = c_drop_p;
        drive(0, 1, 4, 1, 0, 1, 0);
        drive(0, 1, 2, 1, 0, 1, 0);
        chk("B_ready_low_p", 32'(rdy_p), 0);
        chk("B_ready_low_a", 32'(rdy_a), 0);
        drive(0, 1, 7, 1, 0, 1, 0);
        chk("B_drop_p", 32'(drop_p), 1);
        chk("B_drop_a", 32'(drop_a), 1);
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, (i % 4) < 2, 1, 0);
        chk("B_done_p", 32'(c_done_p - dp), 2);
        chk("B_done_a", 32'(c_done_a - da), 2);
        chk("B_ren_cycles_p", 32'(c_ren_p - rp), 23);
        chk("B_ren_cycles_a", 32'(c_ren_a - ra), 12);
        chk("B_no_gap_p", 32'(c_fall_p - fp), 1);
        chk("B_no_gap_a", 32'(c_fall_a - fa), 1);
        chk("B_drop_once", 32'(c_drop_p - dr), 1);

        // run_verif_i low for 5 cycles at remaining 7
        dp = c_done_p; da = c_done_a; aa = c_ab_a;
        drive(0, 1, 9, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, (i % 2) == 0, 1, 0);
        chk("C_rem7_p", 32'(rem_p), 7);
        chk("C_rem7_a", 32'(rem_a), 7);
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, (i % 2) == 0, 0, 0);
        chk("C_pause_ren", 32'(ren_p), 0);
        chk("C_pause_rem", 32'(rem_p), 7);
        chk("C_pause_busy", 32'(busy_p), 1);
        chk("C_abort_busy", 32'(busy_a), 0);
        chk("C_abort_rem", 32'(rem_a), 0);
        chk("C_abort_pulse", 32'(c_ab_a - aa), 1);
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 0, (i % 2) == 1, 1, 0);
            if (i == 0) chk("C_resume_ren", 32'(ren_p), 1);
        end
        chk("C_done_p", 32'(c_done_p - dp), 1);
        chk("C_done_a", 32'(c_done_a - da), 0);
        chk("C_end_busy", 32'(busy_p), 0);

        // abort_i together with a command
        drive(0, 1, 5, 1, 0, 1, 0);
        drive(0, 1, 6, 1, 0, 1, 1);
        chk("D_busy", 32'(busy_p), 0);
        chk("D_rem", 32'(rem_p), 0);
        chk("D_aborted_p", 32'(ab_p), 1);
        chk("D_aborted_a", 32'(ab_a), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("D_not_accepted", 32'(busy_p), 0);

        // L=0: done pulse only
        rp = c_ren_p;
        drive(0, 1, 0, 1, 0, 1, 0);
        chk("E_done", 32'(done_p), 1);
        chk("E_busy", 32'(busy_p), 0);
        chk("E_ren", 32'(ren_p), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("E_done_once", 32'(done_p), 0);
        chk("E_ren_never", 32'(c_ren_p - rp), 0);

        // Maximum length, then reset mid-window
        drive(0, 1, 32767, 1, 0, 1, 0);
        chk("F_rem_max_p", 32'(rem_p), 32767);
        chk("F_rem_max_a", 32'(rem_a), 32767);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("F_rem_dec", 32'(rem_p), 32766);
        drive(1, 0, 0, 0, 0, 1, 0);
        chk("F_rst_ready", 32'(rdy_p), 0);
        chk("F_rst_ren", 32'(ren_p), 0);
        chk("F_rst_busy", 32'(busy_a), 0);
        chk("F_rst_rem", 32'(rem_p), 0);
        chk("F_rst_done", 32'(done_p), 0);
        chk("F_rst_aborted", 32'(ab_p), 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("F_ready_back", 32'(rdy_p), 1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 9) < 3,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) != 0,
                  $urandom_range(0, 49) == 0);
        end
        drive(0, 0, 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stim_window_ctrl.md
Name: stim_window_ctrl

Overview:
- Generates the stimulus-enable window for the emulation verification controller.
- A start command carries a window length L. The block holds r_en_stimuli_o high until L user-clock ticks have been counted while verification runs.
- Successor of the fixed 15-bit optimisation-stimulus enable, adding:
  - parametrised length width;
  - a one-deep pending-command slot, so back-to-back windows run seamlessly;
  - a selectable pause-or-abort reaction to run_verif_i dropping;
  - an explicit abort input;
  - done and aborted status pulses.
- Sits between the command decoder (count/valid words) and the stimuli FIFO read-enable.

Parameters:
- CNT_W, 15: width of the window length L and of the remaining-tick counter.
- EDGE_DETECT, 1: 1 counts rising edges of user_tick_i; 0 counts every clk_ref cycle in which user_tick_i is high.
- PAUSE_MODE, 1: 1 pauses the window while run_verif_i is low; 0 aborts it.

Ports:
- clk_ref  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  command word valid.
- cmd_i  in  CNT_W+1  bit0 is the start flag; bits [CNT_W:1] are L.
- user_tick_i  in  1  user-clock level, sampled on clk_ref.
- run_verif_i  in  1  verification running.
- abort_i  in  1  synchronous abort request.
- cmd_ready_o  out  1  a command can be accepted this cycle.
- r_en_stimuli_o  out  1  stimulus read enable.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse when a window completes.
- aborted_o  out  1  one-cycle pulse when a window or pending command is discarded.
- cmd_drop_o  out  1  one-cycle pulse when a command arrives while cmd_ready_o is low.
- remaining_o  out  CNT_W  ticks left in the current window.

Behaviour:
- Reset: all outputs 0, state IDLE, pending slot empty, tick_q 0.
  - cmd_ready_o is 0 during the reset cycle and 1 on the first cycle after it.
- States: IDLE, ACTIVE, PAUSED. PAUSED is reachable only when PAUSE_MODE=1.
- Counted tick (tick):
  - EDGE_DETECT=1: user_tick_i & ~tick_q. tick_q registers user_tick_i every cycle.
  - EDGE_DETECT=0: user_tick_i.
- Accept condition: cmd_valid_i & cmd_i[0] & cmd_ready_o.
  - A command with cmd_i[0]=0 is ignored with no pulse.
  - cmd_ready_o = !rst & (IDLE or pending slot empty).
- IDLE, accept at edge t:
  - State ACTIVE; r_en_stimuli_o=1 and remaining_o=L visible after edge t.
  - A tick in the acceptance cycle is not counted.
  - Accept does not depend on run_verif_i.
- L=0: accepted but no window runs. State stays IDLE, r_en_stimuli_o stays 0, done_o pulses the next cycle.
- ACTIVE with run_verif_i=1: each tick decrements remaining_o.
- Completion is a tick while remaining_o==1. At the next edge done_o pulses, and:
  - if the pending slot is valid: its L loads, state stays ACTIVE, r_en_stimuli_o stays high with no gap, slot clears;
  - if the pending slot is empty but a command is accepted in the completion cycle: that command loads the same way;
  - otherwise: IDLE, r_en_stimuli_o=0, remaining_o=0.
  - A pending L=0 loaded this way completes on the following cycle with r_en_stimuli_o low.
- ACTIVE, accept with an empty slot: L is stored in the pending slot; cmd_ready_o falls next cycle.
- cmd_valid_i & cmd_i[0] & !cmd_ready_o: command is dropped and cmd_drop_o pulses.
- ACTIVE with run_verif_i=0:
  - PAUSE_MODE=1: next state PAUSED, r_en_stimuli_o=0, remaining_o holds, ticks are ignored.
    - PAUSED with run_verif_i=1: next state ACTIVE, r_en_stimuli_o=1.
    - Accepts into an empty pending slot are still allowed in PAUSED.
  - PAUSE_MODE=0: next state IDLE, the pending slot clears, aborted_o pulses.
- abort_i, highest priority after rst:
  - Next state IDLE; r_en_stimuli_o, remaining_o and the pending slot clear.
  - A command presented in the same cycle is discarded, not accepted.
  - aborted_o pulses only if the block was busy or the slot was valid.
- Arithmetic: remaining_o is unsigned CNT_W bits and never wraps; decrement happens only when it is ≥1.
  - L = 2^CNT_W-1 is legal.
- Reset mid-window: at the reset edge everything returns to reset values; no done_o or aborted_o pulse.

Decomposition:
- Package stim_ctrl_pkg:
  - state enum (IDLE, ACTIVE, PAUSED);
  - default CNT_W;
  - field constants CMD_START_BIT=0, CMD_LEN_LSB=1.
- Sub-module stim_tick_detect:
  - contains tick_q and the EDGE_DETECT mux;
  - outputs the one-bit tick.
- Everything else lives in one FSM-plus-datapath module.

Test Plan:
- EDGE_DETECT=1, cmd_i={L=3,1} accepted at edge t, user_tick_i toggling every 2 cycles:
  - r_en_stimuli_o high from t+1 until the edge after the third rising edge;
  - done_o pulses once; remaining_o steps 3,2,1,0.
- Back-to-back: L=4 running, then L=2 accepted while ACTIVE:
  - cmd_ready_o goes 0; r_en_stimuli_o stays high for 6 ticks with no gap;
  - two done_o pulses.
- Third command while the slot is full: cmd_drop_o pulses for 1 cycle; the window sequence is unaffected.
- PAUSE_MODE=1, run_verif_i low for 5 cycles at remaining_o=7 with ticks present:
  - r_en_stimuli_o low, remaining_o holds 7;
  - resumes and completes after 7 further ticks.
- PAUSE_MODE=0, same stimulus: next cycle IDLE, aborted_o=1, pending slot cleared, no done_o.
- Corner cases:
  - abort_i together with cmd_valid_i → IDLE, command not accepted;
  - L=0 → done_o pulse only, r_en_stimuli_o never high;
  - rst mid-window → all outputs 0 the next cycle.
